packet_injector: RTL
====================

PACKET_INJECTOR -- requirements
Module: packet_injector

Interface
REQ-001 SHALL have parameter MAX_PKT_LEN, default 8, giving the maximum flits per packet (>=2).
REQ-002 SHALL have parameter LEN_W, default 4, giving the width of the packet length field (2^LEN_W > MAX_PKT_LEN).
REQ-003 SHALL have ports: clk input 1, the single clock; rst input 1, asynchronous active-high reset.
REQ-004 SHALL have port pkt_valid_i input 1: packet descriptor offered.
REQ-005 SHALL have port pkt_len_i input LEN_W: packet length in flits.
REQ-006 SHALL have port pkt_vc_i input VC_SIZE: target downstream VC.
REQ-007 SHALL have port pkt_head_data_i input (flit_t data width): head flit payload.
REQ-008 SHALL have port pkt_ready_o output 1: descriptor accepted when high with pkt_valid_i.
REQ-009 SHALL have port payload_valid_i input 1: body/tail payload offered.
REQ-010 SHALL have port payload_i input (flit_t data width): body/tail payload.
REQ-011 SHALL have port payload_ready_o output 1: payload consumed when high with payload_valid_i.
REQ-012 SHALL have port on_off_i input VC_NUM: per-VC downstream on/off; 1 = VC may receive.
REQ-013 SHALL have port valid_flit_o output 1: data_o carries a flit this cycle.
REQ-014 SHALL have port data_o output flit_t: emitted flit (label, vc_id, data).
REQ-015 SHALL have port busy_o output 1: high while not IDLE.
REQ-016 SHALL have port error_o output 1: one-cycle pulse on a rejected descriptor.

Function
REQ-017 SHALL implement FSM states IDLE, HEAD, BODY; busy_o = (state != IDLE).
REQ-018 SHALL assert pkt_ready_o only in IDLE; payload_ready_o only in BODY when on_off_i[vc] is 1.
REQ-019 On accept with 1 <= pkt_len_i <= MAX_PKT_LEN, SHALL latch len, vc and head data and go to HEAD.
REQ-020 On accept with pkt_len_i = 0 or > MAX_PKT_LEN, SHALL drop the descriptor, stay in IDLE and pulse error_o on the next cycle.
REQ-021 In HEAD, when on_off_i[vc] is 1, SHALL register a flit: label HEADTAIL if len = 1 (next state IDLE), else HEAD (next state BODY, remaining = len-1); if on_off_i[vc] is 0, SHALL hold HEAD.
REQ-022 In BODY, when on_off_i[vc] and payload_valid_i are both 1, SHALL register a flit with data payload_i, labelled TAIL if remaining = 1 (next state IDLE), else BODY; SHALL decrement remaining; otherwise SHALL emit nothing.
REQ-023 All emitted flits SHALL carry vc_id = latched vc; data_o is registered: 1-cycle latency from the emit decision to valid_flit_o.
REQ-024 valid_flit_o SHALL be high for exactly one cycle per flit; data_o SHALL hold its last value while valid_flit_o is low.
REQ-025 on_off_i deasserting mid-packet SHALL stall emission without loss or reordering; resumption SHALL continue from the same remaining count.
REQ-026 SHALL emit exactly len flits per accepted packet, in order HEAD, BODY*, TAIL, or a single HEADTAIL.
REQ-027 Back-to-back: the cycle after a TAIL/HEADTAIL decision SHALL be IDLE with pkt_ready_o = 1.
REQ-028 pkt_* inputs SHALL be ignored outside IDLE; payload_* inputs SHALL be ignored outside BODY.

Reset
REQ-029 On rst: state IDLE, remaining 0, valid_flit_o 0, data_o all-zero, error_o 0, latched vc 0, statistics counters 0.
REQ-030 Reset mid-packet SHALL abandon the packet immediately (asynchronous); no further flits of it SHALL be emitted.

Configuration
REQ-031 With macro INJECTOR_STATS_EN defined, SHALL add outputs flits_sent_o and packets_sent_o (16 bits each), incremented on each valid_flit_o and on each TAIL/HEADTAIL emitted, wrapping 0xFFFF -> 0.
REQ-032 Without INJECTOR_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-033 len=1, vc=2, on_off=all 1 -> one flit HEADTAIL vc_id=2 on valid_flit_o 2 cycles after accept; busy_o back to 0.
REQ-034 len=4, vc=1, payload always valid, on_off=all 1 -> HEAD, BODY, BODY, TAIL on 4 consecutive cycles, vc_id=1, payloads in order.
REQ-035 len=3, on_off_i[vc] dropped for 5 cycles after HEAD -> no flit and payload_ready_o=0 during the stall; BODY, TAIL follow after reassertion.
REQ-036 pkt_len_i=0 and then pkt_len_i=MAX_PKT_LEN+1 -> no flits emitted, error_o pulses once per descriptor, pkt_ready_o stays 1.
REQ-037 rst asserted after the 2nd flit of a len=5 packet -> valid_flit_o 0 at once, state IDLE; the next packet starts with HEAD.
REQ-038 INJECTOR_STATS_EN defined, 3 packets of len 2 -> flits_sent_o=6, packets_sent_o=3.

Source files
------------

// File: rtl/packet_injector.sv
// Turns a packet descriptor plus a stream of payload words into HEAD/BODY/TAIL flits for one downstream VC.
// Flit layout is {label[1:0], vc_id, data}. Define INJECTOR_STATS_EN to add the flit and packet counters.
module packet_injector #(
    parameter int MAX_PKT_LEN = 8,
    parameter int LEN_W       = 4,
    parameter int VC_NUM      = 4,
    parameter int VC_SIZE     = 2,
    parameter int DATA_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pkt_valid_i,
    input  logic [LEN_W-1:0]            pkt_len_i,
    input  logic [VC_SIZE-1:0]          pkt_vc_i,
    input  logic [DATA_W-1:0]           pkt_head_data_i,
    output logic                        pkt_ready_o,
    input  logic                        payload_valid_i,
    input  logic [DATA_W-1:0]           payload_i,
    output logic                        payload_ready_o,
    input  logic [VC_NUM-1:0]           on_off_i,
    output logic                        valid_flit_o,
    output logic [DATA_W+VC_SIZE+1:0]   data_o,
    output logic                        busy_o,
    output logic                        error_o
`ifdef INJECTOR_STATS_EN
    ,
    output logic [15:0]                 flits_sent_o,
    output logic [15:0]                 packets_sent_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    // The label MSB marks the last flit of a packet.
    localparam logic [1:0] LBL_HEAD     = 2'b00;
    localparam logic [1:0] LBL_BODY     = 2'b01;
    localparam logic [1:0] LBL_TAIL     = 2'b10;
    localparam logic [1:0] LBL_HEADTAIL = 2'b11;

    localparam int FLIT_W = DATA_W + VC_SIZE + 2;

    logic [1:0]         state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [VC_SIZE-1:0] vc_q, vc_d;
    logic [DATA_W-1:0]  head_q, head_d;
    logic               valid_q, valid_d;
    logic [FLIT_W-1:0]  data_q, data_d;
    logic               err_q, err_d;
    logic               vc_on;
    logic               len_bad;

    assign vc_on   = on_off_i[vc_q];
    assign len_bad = (pkt_len_i == '0) || (pkt_len_i > LEN_W'(MAX_PKT_LEN));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rem_d   = rem_q;
        vc_d    = vc_q;
        head_d  = head_q;
        valid_d = 1'b0;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pkt_valid_i) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = pkt_len_i;
                        rem_d   = pkt_len_i;
                        vc_d    = pkt_vc_i;
                        head_d  = pkt_head_data_i;
                        state_d = S_HEAD;
                    end
                end
            end
            S_HEAD: begin
                if (vc_on) begin
                    valid_d = 1'b1;
                    if (len_q == LEN_W'(1)) begin
                        data_d  = {LBL_HEADTAIL, vc_q, head_q};
                        rem_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        data_d  = {LBL_HEAD, vc_q, head_q};
                        rem_d   = len_q - LEN_W'(1);
                        state_d = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (vc_on && payload_valid_i) begin
                    valid_d = 1'b1;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        data_d  = {LBL_TAIL, vc_q, payload_i};
                        state_d = S_IDLE;
                    end else begin
                        data_d  = {LBL_BODY, vc_q, payload_i};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            rem_q   <= '0;
            vc_q    <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            vc_q    <= vc_d;
            head_q  <= head_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign pkt_ready_o     = (state_q == S_IDLE);
    assign payload_ready_o = (state_q == S_BODY) && vc_on;
    assign busy_o          = (state_q != S_IDLE);
    assign valid_flit_o    = valid_q;
    assign data_o          = data_q;
    assign error_o         = err_q;

`ifdef INJECTOR_STATS_EN
    logic [15:0] flits_q;
    logic [15:0] pkts_q;

    // Counted on the emit decision so the totals line up with the flit on data_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flits_q <= '0;
            pkts_q  <= '0;
        end else if (valid_d) begin
            flits_q <= flits_q + 16'd1;
            if (data_d[FLIT_W-1]) begin
                pkts_q <= pkts_q + 16'd1;
            end
        end
    end

    assign flits_sent_o   = flits_q;
    assign packets_sent_o = pkts_q;
`endif

endmodule
